// File: rtl/mem_rq_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_rq_pkg
// Brief  : Shared state encoding and request field layout for the 65-bit
//          get/put memory request channel.
// Rev    : 1.0  initial release
// ============================================================================
package mem_rq_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD_RQ = 3'd1,
      RD_RS = 3'd2,
      WR_RQ = 3'd3,
      WR_RS = 3'd4,
      FIN   = 3'd5
   } state_t;

   localparam int RQ_W        = 65;
   localparam int RQ_ADDR_MSB = 64;
   localparam int RQ_ADDR_LSB = 33;
   localparam int RQ_ISWRITE  = 32;
   localparam int RQ_DATA_MSB = 31;
   localparam int WORD_BYTES  = 4;

   function automatic logic [RQ_W-1:0] make_rq(input logic [31:0] addr,
                                                input logic        iswrite,
                                                input logic [31:0] data);
      logic [RQ_W-1:0] r;
      r                            = '0;
      r[RQ_ADDR_MSB:RQ_ADDR_LSB]   = addr;
      r[RQ_ISWRITE]                = iswrite;
      r[RQ_DATA_MSB:0]             = data;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_copy_initiator.sv
`default_nettype none
// ============================================================================
// Module : mem_copy_initiator
// Brief  : Bus-master word copier (read-then-write per word) on the get/put
//          memory protocol. Optional running checksum: define MEMCPY_CSUM_EN.
// Rev    : 1.0  initial release
// ============================================================================
module mem_copy_initiator
   import mem_rq_pkg::*;
#(
   parameter int LEN_W = 16
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             start,
   input  logic [31:0]      src,
   input  logic [31:0]      dst,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   output logic             done,
   output logic             rq_valid,
   input  logic             rq_ready,
   output logic [RQ_W-1:0]  rq,
   input  logic             rs_valid,
   input  logic [31:0]      rs_data,
   output logic [31:0]      csum
);

   state_t           state;
   logic [31:0]      cur_src;
   logic [31:0]      cur_dst;
   logic [LEN_W-1:0] remaining;
   logic [31:0]      nxt_src;
   logic [31:0]      nxt_dst;
   logic             accept;

   assign accept  = (state == IDLE) && start;
   assign nxt_src = cur_src + 32'(WORD_BYTES);
   assign nxt_dst = cur_dst + 32'(WORD_BYTES);

   // The read word is held in rq[31:0] from the read response until the write transfers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         rq_valid  <= 1'b0;
         rq        <= '0;
         cur_src   <= '0;
         cur_dst   <= '0;
         remaining <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  cur_src   <= src;
                  cur_dst   <= dst;
                  remaining <= len;
                  if (len == '0) begin
                     state <= FIN;
                     done  <= 1'b1;
                  end else begin
                     state    <= RD_RQ;
                     busy     <= 1'b1;
                     rq_valid <= 1'b1;
                     rq       <= make_rq(src, 1'b0, 32'h0);
                  end
               end
            end
            RD_RQ: begin
               if (rq_ready) begin
                  state    <= RD_RS;
                  rq_valid <= 1'b0;
               end
            end
            RD_RS: begin
               if (rs_valid) begin
                  state    <= WR_RQ;
                  rq_valid <= 1'b1;
                  rq       <= make_rq(cur_dst, 1'b1, rs_data);
               end
            end
            WR_RQ: begin
               if (rq_ready) begin
                  state    <= WR_RS;
                  rq_valid <= 1'b0;
               end
            end
            WR_RS: begin
               if (rs_valid) begin
                  cur_src   <= nxt_src;
                  cur_dst   <= nxt_dst;
                  remaining <= remaining - LEN_W'(1);
                  if (remaining == LEN_W'(1)) begin
                     state <= FIN;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state    <= RD_RQ;
                     rq_valid <= 1'b1;
                     rq       <= make_rq(nxt_src, 1'b0, 32'h0);
                  end
               end
            end
            FIN: begin
               state <= IDLE;
            end
            default: begin
               state    <= IDLE;
               busy     <= 1'b0;
               rq_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef MEMCPY_CSUM_EN
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         csum <= '0;
      end else if (accept) begin
         csum <= '0;
      end else if ((state == RD_RS) && rs_valid) begin
         csum <= csum + rs_data;
      end
   end
`else
   logic unused_accept;
   assign unused_accept = accept;
   assign csum          = '0;
`endif

   // Responses are only legal while a request is outstanding.
   rs_only_when_waiting: assert property (@(posedge CLK) disable iff (!RST_N)
      rs_valid |-> ((state == RD_RS) || (state == WR_RS)));

endmodule
`default_nettype wire

// File: tb/tb_mem_copy_initiator.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_copy_initiator
// Brief  : Self-checking bench: word-memory responder plus reference copy model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mem_copy_initiator;
   import mem_rq_pkg::*;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        start = 1'b0;
   logic [31:0] src = '0;
   logic [31:0] dst = '0;
   logic [15:0] len = '0;
   logic        busy, done, rq_valid;
   logic        rq_ready = 1'b0;
   logic [64:0] rq;
   logic        rs_valid = 1'b0;
   logic [31:0] rs_data = '0;
   logic [31:0] csum;

   mem_copy_initiator #(.LEN_W(16)) dut (
      .CLK(CLK), .RST_N(RST_N), .start(start), .src(src), .dst(dst), .len(len),
      .busy(busy), .done(done), .rq_valid(rq_valid), .rq_ready(rq_ready), .rq(rq),
      .rs_valid(rs_valid), .rs_data(rs_data), .csum(csum)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int  t0 = 0;
   bit  running = 1'b0;
   int  done_cnt, busy_cnt, done_cyc, wr_seen, rq_cnt;
   int  cfg_lat = 1, cfg_stall = 0;
   bit  cfg_rnd = 1'b0;
   logic [64:0] exp_q[$];
   logic [31:0] mem [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];

   bit          pend = 1'b0;
   int          pend_cd = 0;
   logic [31:0] pend_data = '0;
   bit          held_valid = 1'b0;
   logic [64:0] held_rq = '0;
   int          wait_cnt = 0;

   task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input logic [64:0] act);
      checks++;
      failures++;
      $display("FAIL %s actual=%0h required=none", name, act);
   endtask

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return (a >> 2) + 32'd1;
   endfunction

   function automatic logic [31:0] rotr(input logic [31:0] w, input logic [1:0] b);
      return (w >> (8 * b)) | (w << (32 - 8 * b));
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] al;
      al = {a[31:2], 2'b00};
      return mem.exists(al) ? mem[al] : init_word(al);
   endfunction

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      logic [31:0] al;
      al = {a[31:2], 2'b00};
      return ref_mem.exists(al) ? ref_mem[al] : init_word(al);
   endfunction

   // Responder and monitor, evaluated between rising edges.
   always @(negedge CLK) begin
      if (running) begin
         if (done) begin
            done_cnt++;
            done_cyc = cyc - t0 + 1;
         end
         if (busy) busy_cnt++;
      end
      if (!RST_N) begin
         pend       = 1'b0;
         rs_valid   = 1'b0;
         rq_ready   = 1'b0;
         held_valid = 1'b0;
         wait_cnt   = 0;
      end else begin
         rs_valid = 1'b0;
         if (pend) begin
            pend_cd--;
            if (pend_cd == 0) begin
               rs_valid = 1'b1;
               rs_data  = pend_data;
               pend     = 1'b0;
            end
         end
         if (rq_valid) begin
            if (held_valid) check("rq_stable", rq, held_rq);
            if (cfg_rnd) rq_ready = 1'($urandom_range(0, 1));
            else         rq_ready = (wait_cnt >= cfg_stall);
            wait_cnt++;
            if (rq_ready) begin
               if (pend || rs_valid) fail_now("outstanding", rq);
               rq_cnt++;
               if (exp_q.size() == 0) fail_now("rq_extra", rq);
               else                   check("rq", rq, exp_q.pop_front());
               if (rq[RQ_ISWRITE]) begin
                  mem[{rq[RQ_ADDR_MSB:RQ_ADDR_LSB+2], 2'b00}] = rq[31:0];
                  pend_data = $urandom;
                  wr_seen++;
               end else begin
                  pend_data = rotr(mem_word(rq[RQ_ADDR_MSB:RQ_ADDR_LSB]), rq[RQ_ADDR_LSB+1:RQ_ADDR_LSB]);
               end
               pend       = 1'b1;
               pend_cd    = cfg_lat;
               wait_cnt   = 0;
               held_valid = 1'b0;
            end else begin
               held_valid = 1'b1;
               held_rq    = rq;
            end
         end else begin
            rq_ready = 1'b0;
         end
      end
   end

   // Reference: ascending word copy over a byte-addressed memory with rotating reads.
   task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                             output logic [31:0] sum);
      logic [31:0] w, sa, da;
      sum = '0;
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
         sa = s + 32'(4 * i);
         da = d + 32'(4 * i);
         w  = rotr(ref_word(sa), sa[1:0]);
         exp_q.push_back({sa, 1'b0, 32'h0});
         exp_q.push_back({da, 1'b1, w});
         ref_mem[{da[31:2], 2'b00}] = w;
         sum += w;
      end
   endtask

   task automatic launch(input logic [31:0] s, input logic [31:0] d, input int n);
      done_cnt = 0; busy_cnt = 0; done_cyc = -1; wr_seen = 0; rq_cnt = 0;
      @(negedge CLK);
      start = 1'b1; src = s; dst = d; len = 16'(n);
      @(posedge CLK); #1;
      t0 = cyc;
      running = 1'b1;
      @(negedge CLK);
      start = 1'b0;
   endtask

   task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                           input int lat, input int stall, input bit rnd, input int exp_done,
                           input bit csum_fixed, input logic [31:0] csum_val);
      logic [31:0] sum;
      int k;
      model_copy(s, d, n, sum);
      cfg_lat = lat; cfg_stall = stall; cfg_rnd = rnd;
      launch(s, d, n);
      k = 0;
      while (done_cnt == 0 && k < 3000) begin
         @(negedge CLK); #1;
         k++;
      end
      if (done_cnt == 0) fail_now("done_timeout", 65'(k));
      repeat (4) @(negedge CLK);
      #1;
      running = 1'b0;
      check("done_count", 65'(done_cnt), 65'd1);
      if (exp_done >= 0) check("done_cycle", 65'(done_cyc), 65'(exp_done));
      check("busy_cycles", 65'(busy_cnt), 65'(done_cyc - 1));
      check("rq_count", 65'(rq_cnt), 65'(2 * n));
      check("rq_left", 65'(exp_q.size()), 65'd0);
      for (int i = 0; i < n; i++)
         check("mem_word", 65'(mem_word(d + 32'(4 * i))), 65'(ref_word(d + 32'(4 * i))));
`ifdef MEMCPY_CSUM_EN
      check("csum", 65'(csum), 65'(csum_fixed ? csum_val : sum));
`else
      if (csum_fixed || sum != 32'h0 || csum_val != 32'h0) check("csum", 65'(csum), 65'd0);
      else                                                 check("csum", 65'(csum), 65'd0);
`endif
   endtask

   typedef struct {
      logic [31:0] s;
      logic [31:0] d;
      int          n;
      int          lat;
      int          stall;
      int          exp_done;
      bit          csum_fixed;
      logic [31:0] csum_val;
   } vec_t;

   initial begin
      vec_t        vecs[6];
      logic [31:0] sum;
      int          k;

      vecs[0] = '{32'h0000_0000, 32'h0000_0040, 4, 1, 0, 17, 1'b1, 32'hA};
      vecs[1] = '{32'h0000_0010, 32'h0000_0020, 0, 1, 0,  1, 1'b1, 32'h0};
      vecs[2] = '{32'h0000_0100, 32'h0000_0200, 3, 3, 3, -1, 1'b0, 32'h0};
      vecs[3] = '{32'hFFFF_FFFC, 32'h0000_0300, 2, 1, 0,  9, 1'b0, 32'h0};
      vecs[4] = '{32'h0000_0001, 32'h0000_0400, 1, 1, 0,  5, 1'b0, 32'h0};
      vecs[5] = '{32'h0000_0500, 32'h0000_0504, 4, 2, 1, -1, 1'b0, 32'h0};

      repeat (3) @(negedge CLK);
      check("rst_busy",     65'(busy),     65'd0);
      check("rst_done",     65'(done),     65'd0);
      check("rst_rq_valid", 65'(rq_valid), 65'd0);
      check("rst_rq",       rq,            65'd0);
      check("rst_csum",     65'(csum),     65'd0);
      RST_N = 1'b1;
      @(negedge CLK);

      for (int i = 0; i < 6; i++) begin
         run_copy(vecs[i].s, vecs[i].d, vecs[i].n, vecs[i].lat, vecs[i].stall, 1'b0,
                  vecs[i].exp_done, vecs[i].csum_fixed, vecs[i].csum_val);
         if (i == 0) check("mem_0x4c", 65'(mem_word(32'h4C)), 65'd4);
      end

      // Start pulsed again while in FIN must not launch a second copy.
      exp_q.delete();
      cfg_lat = 1; cfg_stall = 0; cfg_rnd = 1'b0;
      launch(32'h10, 32'h20, 0);
      start = 1'b1; len = 16'd2;
      @(negedge CLK);
      start = 1'b0;
      repeat (8) @(negedge CLK);
      #1;
      running = 1'b0;
      check("fin_done_count", 65'(done_cnt), 65'd1);
      check("fin_done_cycle", 65'(done_cyc), 65'd1);
      check("fin_busy",       65'(busy_cnt), 65'd0);
      check("fin_rq_count",   65'(rq_cnt),   65'd0);

      // Mid-copy restart is ignored; reset during a write response aborts cleanly.
      model_copy(32'h600, 32'h700, 3, sum);
      cfg_lat = 3;
      launch(32'h600, 32'h700, 3);
      repeat (2) @(negedge CLK);
      start = 1'b1; src = 32'h800; dst = 32'h900; len = 16'd1;
      @(negedge CLK);
      start = 1'b0;
      k = 0;
      while (wr_seen == 0 && k < 200) begin
         @(negedge CLK); #1;
         k++;
      end
      if (wr_seen == 0) fail_now("wr_timeout", 65'(k));
      @(posedge CLK); #1;
      RST_N = 1'b0;
      #1;
      check("abort_busy",     65'(busy),     65'd0);
      check("abort_rq_valid", 65'(rq_valid), 65'd0);
      @(posedge CLK); #1;
      RST_N = 1'b1;
      exp_q.delete();
      ref_mem = mem;
      done_cnt = 0; busy_cnt = 0; rq_cnt = 0;
      repeat (10) @(negedge CLK);
      #1;
      running = 1'b0;
      check("abort_no_done",  65'(done_cnt), 65'd0);
      check("abort_idle",     65'(busy_cnt), 65'd0);
      check("abort_no_rq",    65'(rq_cnt),   65'd0);
      run_copy(32'h600, 32'h780, 3, 1, 0, 1'b0, 13, 1'b0, 32'h0);

      for (int i = 0; i < 12; i++)
         run_copy(32'($urandom_range(0, 1023)), 32'h1000 + 32'($urandom_range(0, 1023)),
                  int'($urandom_range(0, 6)), int'($urandom_range(1, 4)), 0, 1'b1, -1, 1'b0, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_copy_initiator.md
Name: mem_copy_initiator

Overview:
- Request initiator (bus master) for the 65-bit get/put memory protocol. It is the same protocol that the word RAM answers as responder.
- On a start pulse, copies LEN 32-bit words from byte address SRC to byte address DST. Each word is one read request followed by one write request.
- Sits beside the processor core as a second requester, ahead of an arbiter, or drives the RAM directly in loader and bring-up builds.

Parameters:
- LEN_W, 16, width of the word-count input; maximum copy is 2^LEN_W-1 words.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- src  in  32  source byte address; unaligned allowed.
- dst  in  32  destination byte address; unaligned allowed.
- len  in  LEN_W  number of words to copy.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the copy completes.
- rq_valid  out  1  request offered (RDY side of the get).
- rq_ready  in  1  request taken this cycle (EN side of the get).
- rq  out  65  {addr[64:33], iswrite[32], data[31:0]}.
- rs_valid  in  1  response present (EN of the put); the initiator is always ready.
- rs_data  in  32  response word.
- csum  out  32  running checksum (MEMCPY_CSUM_EN only; otherwise tied 0).

Behaviour:
- Reset (async assert, sync release on CLK):
  - state=IDLE; busy=0, done=0, rq_valid=0, rq=0, csum=0.
  - Internal address and count registers are cleared.
- Protocol:
  - A request transfers on a cycle where rq_valid && rq_ready.
  - rq is held stable while rq_valid=1 and the request is not yet taken.
  - Every transferred request produces exactly one response, in order, at any latency of 1 cycle or more.
  - Write responses carry no meaning and are consumed and discarded.
  - At most one request is outstanding.
- States:
  - IDLE: on start, latch src, dst, len; go to FIN if len==0, else RD_RQ.
  - RD_RQ: rq_valid=1, rq={cur_src,0,32'h0}. On transfer, go to RD_RS.
  - RD_RS: rq_valid=0. On rs_valid, latch rs_data into the data register and go to WR_RQ.
  - WR_RQ: rq_valid=1, rq={cur_dst,1,data}. On transfer, go to WR_RS.
  - WR_RS: on rs_valid, do cur_src+=4, cur_dst+=4, remaining-=1. Then go to FIN if the old remaining==1, else RD_RQ.
  - FIN: done=1 for exactly one cycle, busy=0, then IDLE.
- busy=1 in RD_RQ..WR_RS; busy=0 in IDLE and FIN.
- Timing with a 1-cycle responder and rq_ready tied 1:
  - start sampled at edge 0; first read request at cycle 1.
  - 4 cycles per word.
  - done asserted in cycle 4N+1 for N≥1; for len==0, done in cycle 1.
- Address arithmetic is modulo 2^32; 32'hFFFFFFFC+4 wraps to 0.
- start outside IDLE (including during FIN) is ignored.
- An rs_valid seen in IDLE, RD_RQ, WR_RQ or FIN is a protocol error. It is ignored in synthesis and asserts in simulation.
- Asynchronous reset mid-copy returns to IDLE immediately.
  - No done pulse is produced.
  - A response still in flight after reset release is dropped by the IDLE rule above.
- Overlapping src/dst ranges are copied in ascending order with no correction.

Optional Feature:
- Macro: MEMCPY_CSUM_EN.
- Defined:
  - csum is cleared when start is accepted.
  - On each read response, csum <= (csum + rs_data) mod 2^32.
  - csum is valid from done onward and holds until the next accepted start.
- Undefined: csum is constant 0 and no adder is built.

Decomposition:
- Shared package mem_rq_pkg holds:
  - state enum {IDLE, RD_RQ, RD_RS, WR_RQ, WR_RS, FIN};
  - field constants RQ_ADDR_MSB=64, RQ_ADDR_LSB=33, RQ_ISWRITE=32, RQ_DATA_MSB=31;
  - RQ_W=65 and WORD_BYTES=4.
- Single module; no sub-module needed. The checksum is a guarded always block.

Test Plan:
- 1-cycle RAM responder, rq_ready=1, mem[0..3]=1,2,3,4, src=0x0, dst=0x40, len=4 -> mem[0x40..0x4C]=1,2,3,4, done at cycle 17, 8 requests total, csum=0xA with MEMCPY_CSUM_EN.
- len=0 -> no rq_valid ever, done pulse in cycle 1, busy never 1.
- rq_ready held low 3 cycles in RD_RQ and WR_RQ, responder latency 3 -> rq stable while stalled, copy correct, one outstanding request max.
- src=0xFFFFFFFC, len=2 -> second read address 0x00000000.
- src=0x1 (unaligned), len=1 -> read rq addr 0x1, write rq addr dst, data equals the responder's rotated word.
- start re-pulsed mid-copy, then RST_N low for 1 cycle mid-WR_RS -> second start ignored; after reset busy=0, done never pulses, next start copies correctly.
